// File: rtl/diag_seq_pkg.sv
// Shared types and diag function codes for the diag_seq command sequencer.
// DIAG_IDLE / DIAG_STEP_CLOCK alias the CLK module's tDiagFunction encodings.
package diag_seq_pkg;

  localparam int unsigned DIAG_DS_W   = 7;
  localparam int unsigned DIAG_DATA_W = 18;

  typedef enum logic [1:0] {
    OP_FUNC      = 2'd0,
    OP_WRITE     = 2'd1,
    OP_READ      = 2'd2,
    OP_COND_STEP = 2'd3
  } tDiagSeqOp;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_TIMEOUT = 2'd1,
    STAT_ILLEGAL = 2'd2
  } tDiagSeqStatus;

  typedef struct packed {
    tDiagSeqOp              op;
    logic [DIAG_DS_W-1:0]   func;
    logic [DIAG_DATA_W-1:0] data;
  } tDiagSeqCmd;

  localparam logic [DIAG_DS_W-1:0] DIAG_IDLE       = 7'o000;
  localparam logic [DIAG_DS_W-1:0] DIAG_STEP_CLOCK = 7'o002;

endpackage

// File: rtl/diag_seq_fifo.sv
// Synchronous command FIFO for diag_seq; DEPTH must be a power of 2.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module diag_seq_fifo
  import diag_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = tDiagSeqCmd
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  T            mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    head     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/diag_seq.sv
// diag_seq: queued diagnostic-command sequencer driving the EBUS diag lines.
// Define DIAG_SEQ_READ_EN to enable READ sampling; otherwise READ answers ILLEGAL.
module diag_seq
  import diag_seq_pkg::*;
#(
  parameter int unsigned DS_W          = 7,
  parameter int unsigned DATA_W        = 18,
  parameter int unsigned STROBE_CYCLES = 9,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned POLL_CYCLES   = 5,
  parameter int unsigned MAX_STEPS     = 5
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DS_W-1:0]   cmd_func,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DS_W-1:0]   ds,
  output logic              diag_strobe,
  output logic              ebus_drive,
  output logic [DATA_W-1:0] ebus_data_out,
  input  logic [DATA_W-1:0] ebus_data_in,
  input  logic              cond_in,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_STROBE, S_GAP, S_POLL, S_RESP} tDiagSeqState;

  typedef struct packed {
    tDiagSeqOp         op;
    logic [DS_W-1:0]   func;
    logic [DATA_W-1:0] data;
  } tCmd;

  localparam int unsigned CNT_MAX0 = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > POLL_CYCLES) ? CNT_MAX0 : POLL_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned STEP_W   = (MAX_STEPS > 0) ? $clog2(MAX_STEPS + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_ONE     = 1;
  localparam logic [CNT_W-1:0]  STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  POLL_LAST   = CNT_W'((POLL_CYCLES > 0) ? POLL_CYCLES - 1 : 0);
  localparam logic [STEP_W-1:0] STEP_ONE    = 1;
  localparam logic [STEP_W-1:0] STEP_MAX    = STEP_W'(MAX_STEPS);
  localparam logic [DS_W-1:0]   DS_IDLE     = DS_W'(DIAG_IDLE);
  localparam logic [DS_W-1:0]   DS_STEP     = DS_W'(DIAG_STEP_CLOCK);

  tCmd  cmd_in, fifo_head;
  logic fifo_full, fifo_empty, fifo_pop;

  tDiagSeqState      state_q, state_d, after_gap;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  tCmd               cur_q, cur_d;
  tDiagSeqStatus     status_q, status_d;

  logic [DS_W-1:0]   ds_q, ds_d;
  logic              strobe_q, strobe_d;
  logic              drive_q, drive_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rsp_valid_q, rsp_valid_d;
  tDiagSeqStatus     rsp_status_q, rsp_status_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

`ifdef DIAG_SEQ_READ_EN
  logic              rd_cap_q, rd_cap_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
`else
  logic              unused_ebus_in;
  assign unused_ebus_in = ^ebus_data_in;
`endif

  assign cmd_in = '{op: tDiagSeqOp'(cmd_op), func: cmd_func, data: cmd_data};

  diag_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (tCmd)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_l),
    .push      (cmd_valid),
    .push_data (cmd_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_ready     = !fifo_full;
  assign busy          = (state_q != S_IDLE) || !fifo_empty;
  assign ds            = ds_q;
  assign diag_strobe   = strobe_q;
  assign ebus_drive    = drive_q;
  assign ebus_data_out = dout_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_status    = rsp_status_q;
  assign rsp_data      = rsp_data_q;

  // EBUS outputs are decoded from the current state and registered, so they
  // trail the state by one cycle; this sets the pop-to-response latency.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    step_d       = step_q;
    cur_d        = cur_q;
    status_d     = status_q;
    fifo_pop     = 1'b0;
    ds_d         = DS_IDLE;
    strobe_d     = 1'b0;
    drive_d      = 1'b0;
    dout_d       = '0;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    after_gap    = (cur_q.op == OP_COND_STEP) ? S_POLL : S_RESP;
`ifdef DIAG_SEQ_READ_EN
    rd_cap_d     = 1'b0;
    rdata_d      = rd_cap_q ? ebus_data_in : rdata_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_head;
          cnt_d    = '0;
          step_d   = '0;
          status_d = STAT_OK;
          case (fifo_head.op)
            OP_COND_STEP: begin
              cur_d.func = DS_STEP;
              state_d    = S_POLL;
            end
`ifndef DIAG_SEQ_READ_EN
            OP_READ: begin
              status_d = STAT_ILLEGAL;
              state_d  = S_RESP;
            end
`endif
            default: state_d = S_STROBE;
          endcase
        end
      end

      S_STROBE: begin
        ds_d     = cur_q.func;
        strobe_d = 1'b1;
        if (cur_q.op == OP_WRITE) begin
          drive_d = 1'b1;
          dout_d  = cur_q.data;
        end
        if (cnt_q == STROBE_LAST) begin
          cnt_d = '0;
`ifdef DIAG_SEQ_READ_EN
          rd_cap_d = (cur_q.op == OP_READ);
`endif
          if (GAP_CYCLES == 0) state_d = after_gap;
          else                 state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = after_gap;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_POLL: begin
        if (cnt_q == POLL_LAST) begin
          cnt_d = '0;
          if (!cond_in) begin
            state_d = S_RESP;
          end else if (step_q < STEP_MAX) begin
            step_d  = step_q + STEP_ONE;
            state_d = S_STROBE;
          end else begin
            status_d = STAT_TIMEOUT;
            state_d  = S_RESP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_RESP: begin
        rsp_valid_d  = 1'b1;
        rsp_status_d = status_q;
        rsp_data_d   = '0;
        if (cur_q.op == OP_COND_STEP) rsp_data_d = DATA_W'(step_q);
`ifdef DIAG_SEQ_READ_EN
        // With no gap the capture flop is still loading; take the bus directly.
        else if (cur_q.op == OP_READ) rsp_data_d = rd_cap_q ? ebus_data_in : rdata_q;
`endif
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      step_q       <= '0;
      cur_q        <= '0;
      status_q     <= STAT_OK;
      ds_q         <= DS_IDLE;
      strobe_q     <= 1'b0;
      drive_q      <= 1'b0;
      dout_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= STAT_OK;
      rsp_data_q   <= '0;
`ifdef DIAG_SEQ_READ_EN
      rd_cap_q     <= 1'b0;
      rdata_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      cur_q        <= cur_d;
      status_q     <= status_d;
      ds_q         <= ds_d;
      strobe_q     <= strobe_d;
      drive_q      <= drive_d;
      dout_q       <= dout_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
`ifdef DIAG_SEQ_READ_EN
      rd_cap_q     <= rd_cap_d;
      rdata_q      <= rdata_d;
`endif
    end
  end

endmodule

// File: tb/tb_diag_seq.sv
// Directed bench for diag_seq with default parameters; honours DIAG_SEQ_READ_EN.
module tb_diag_seq;
  import diag_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [6:0]  cmd_func;
  logic [17:0] cmd_data;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [17:0] rsp_data;
  logic [6:0]  ds;
  logic        diag_strobe;
  logic        ebus_drive;
  logic [17:0] ebus_data_out;
  logic [17:0] ebus_data_in;
  logic        cond_in;
  logic        busy;

  diag_seq dut (
    .clk           (clk),
    .reset_l       (reset_l),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_func      (cmd_func),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_status    (rsp_status),
    .rsp_data      (rsp_data),
    .ds            (ds),
    .diag_strobe   (diag_strobe),
    .ebus_drive    (ebus_drive),
    .ebus_data_out (ebus_data_out),
    .ebus_data_in  (ebus_data_in),
    .cond_in       (cond_in),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Per-run observations gathered at negedges by watch().
  int         w_strobes, w_rises, w_first_strobe, w_last_strobe;
  int         w_ds_bad, w_drive_cnt, w_drive_bad, w_nrsp, w_first_ready;
  int         rise_idx [8];
  logic [6:0] rise_ds  [8];
  int         rsp_idx  [8];
  int         rsp_st   [8];
  int         rsp_dat  [8];
  int         cond_drop;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0o%0o want 0o%0o", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [6:0] func, input logic [17:0] data);
    int w;
    w = 0;
    while (!cmd_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!cmd_ready) chk("push_ready", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_func  = func;
    cmd_data  = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Index 0 is the middle of the first cycle after the call.
  task automatic watch(input int n_rsp, input int max_cyc,
                       input logic [6:0] exp_ds, input logic [17:0] exp_dout);
    logic prev;
    prev = 1'b0;
    w_strobes = 0; w_rises = 0; w_first_strobe = -1; w_last_strobe = -1;
    w_ds_bad = 0; w_drive_cnt = 0; w_drive_bad = 0; w_nrsp = 0; w_first_ready = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (cmd_ready && w_first_ready < 0) w_first_ready = i;
      if (diag_strobe) begin
        w_strobes++;
        if (!prev) begin
          if (w_rises < 8) begin
            rise_idx[w_rises] = i;
            rise_ds[w_rises]  = ds;
          end
          w_rises++;
          if (w_first_strobe < 0) w_first_strobe = i;
        end
        w_last_strobe = i;
        if (ds != exp_ds) w_ds_bad++;
      end else if (ds != DIAG_IDLE) begin
        w_ds_bad++;
      end
      if (ebus_drive) begin
        w_drive_cnt++;
        if (!diag_strobe || ebus_data_out != exp_dout) w_drive_bad++;
      end else if (ebus_data_out != '0) begin
        w_drive_bad++;
      end
      if (rsp_valid) begin
        if (w_nrsp < 8) begin
          rsp_idx[w_nrsp] = i;
          rsp_st[w_nrsp]  = int'(rsp_status);
          rsp_dat[w_nrsp] = int'(rsp_data);
        end
        w_nrsp++;
      end
      if (!diag_strobe && prev && w_rises == cond_drop) cond_in = 1'b0;
      if (diag_strobe && w_strobes == 8) ebus_data_in = 18'o123456;
      if (!diag_strobe && prev) ebus_data_in = 18'o654321;
      prev = diag_strobe;
      if (n_rsp > 0 && w_nrsp >= n_rsp) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset_l = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_func = '0; cmd_data = '0;
    ebus_data_in = 18'o654321; cond_in = 1'b0; cond_drop = 0;

    repeat (2) @(negedge clk);
    chk("rst_ds", int'(ds), int'(DIAG_IDLE));
    chk("rst_strobe", int'(diag_strobe), 0);
    chk("rst_drive", int'(ebus_drive), 0);
    chk("rst_dout", int'(ebus_data_out), 0);
    chk("rst_rsp", int'({rsp_valid, rsp_status, rsp_data}), 0);
    chk("rst_busy", int'(busy), 0);
    reset_l = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", int'(cmd_ready), 1);

    // FUNC 0o010
    push(2'd0, 7'o010, 18'o0);
    watch(1, 40, 7'o010, 18'o0);
    chk("func_nrsp", w_nrsp, 1);
    chk("func_strobes", w_strobes, 9);
    chk("func_first", w_first_strobe, 2);
    chk("func_last", w_last_strobe, 10);
    chk("func_rsp_at", rsp_idx[0], 15);
    chk("func_status", rsp_st[0], 0);
    chk("func_data", rsp_dat[0], 0);
    chk("func_ds_bad", w_ds_bad, 0);
    chk("func_drive_bad", w_drive_bad + w_drive_cnt, 0);
    @(negedge clk);
    chk("func_rsp_pulse", int'(rsp_valid), 0);
    @(posedge clk); #1;

    // WRITE 0o067 / 0o000120
    push(2'd1, 7'o067, 18'o000120);
    watch(1, 40, 7'o067, 18'o000120);
    chk("wr_drive_cnt", w_drive_cnt, 9);
    chk("wr_drive_bad", w_drive_bad, 0);
    chk("wr_ds_bad", w_ds_bad, 0);
    chk("wr_rsp_at", rsp_idx[0], 15);
    chk("wr_rsp", rsp_st[0] + rsp_dat[0], 0);
    @(posedge clk); #1;

    // READ 0o044
    push(2'd2, 7'o044, 18'o0);
`ifdef DIAG_SEQ_READ_EN
    watch(1, 40, 7'o044, 18'o0);
    chk("rd_strobes", w_strobes, 9);
    chk("rd_rsp_at", rsp_idx[0], 15);
    chk("rd_status", rsp_st[0], 0);
    chk("rd_data", rsp_dat[0], 'o123456);
    @(negedge clk);
    chk("rd_hold", int'(rsp_data), 'o123456);
`else
    watch(1, 40, 7'o044, 18'o0);
    chk("rd_strobes", w_strobes, 0);
    chk("rd_rsp_at", rsp_idx[0], 2);
    chk("rd_status", rsp_st[0], 2);
    chk("rd_data", rsp_dat[0], 0);
    @(negedge clk);
    chk("rd_hold", int'(rsp_status), 2);
`endif
    chk("rd_drive_cnt", w_drive_cnt, 0);
    @(posedge clk); #1;

    // COND_STEP, cond drops after the 2nd step; cmd_func is ignored
    cond_in = 1'b1; cond_drop = 2;
    push(2'd3, 7'o010, 18'o0);
    watch(1, 150, DIAG_STEP_CLOCK, 18'o0);
    chk("cs_rises", w_rises, 2);
    chk("cs_strobes", w_strobes, 18);
    chk("cs_first", w_first_strobe, 7);
    chk("cs_ds_bad", w_ds_bad, 0);
    chk("cs_rsp_at", rsp_idx[0], 43);
    chk("cs_status", rsp_st[0], 0);
    chk("cs_data", rsp_dat[0], 2);
    @(posedge clk); #1;

    // COND_STEP, cond stuck high
    cond_in = 1'b1; cond_drop = 0;
    push(2'd3, 7'o000, 18'o0);
    watch(1, 150, DIAG_STEP_CLOCK, 18'o0);
    chk("to_rises", w_rises, 5);
    chk("to_rsp_at", rsp_idx[0], 97);
    chk("to_status", rsp_st[0], 1);
    chk("to_data", rsp_dat[0], 5);
    cond_in = 1'b0;
    @(posedge clk); #1;

    // Queue: five back-to-back FUNCs 0o011..0o015
    for (int k = 0; k < 5; k++) push(2'd0, 7'(8'o011 + k), 18'o0);
    chk("q_full_ready", int'(cmd_ready), 0);
    chk("q_busy", int'(busy), 1);
    watch(5, 200, 7'o000, 18'o0);
    chk("q_nrsp", w_nrsp, 5);
    chk("q_rises", w_rises, 5);
    chk("q_rsp0_at", rsp_idx[0], 11);
    chk("q_ready_at", w_first_ready, 12);
    chk("q_b2b_gap", rise_idx[1] - rsp_idx[0], 2);
    chk("q_rsp4_at", rsp_idx[4] - rsp_idx[0], 60);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("q_order%0d", k), int'(rise_ds[k]), 'o011 + k);
      chk($sformatf("q_status%0d", k), rsp_st[k], 0);
    end
    @(posedge clk); #1;

    // Reset during the 5th strobe cycle of a WRITE, with a FUNC queued behind it
    push(2'd1, 7'o067, 18'o000120);
    push(2'd0, 7'o010, 18'o0);
    n = 0;
    for (int i = 0; i < 40 && n < 5; i++) begin
      @(negedge clk);
      if (diag_strobe) n++;
    end
    chk("rst5_reached", n, 5);
    reset_l = 1'b0;
    #1;
    chk("rst5_strobe", int'(diag_strobe), 0);
    chk("rst5_drive", int'(ebus_drive), 0);
    chk("rst5_busy", int'(busy), 0);
    chk("rst5_rsp", int'(rsp_valid), 0);
    @(negedge clk);
    reset_l = 1'b1;
    @(posedge clk); #1;
    chk("rst5_ready", int'(cmd_ready), 1);
    watch(0, 30, 7'o000, 18'o0);
    chk("rst5_no_rsp", w_nrsp, 0);
    chk("rst5_no_strobe", w_strobes, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
